// File: rtl/snn_rate_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : snn_rate_decoder_if
// Purpose  : Count-word read stream of the SNN rate decoder (valid/ready).
//            master = decoder (drives words), slave = consumer (drives ready).
// Revision : 1.0 - initial release
// ============================================================================
interface snn_rate_decoder_if #(
  parameter int N_OUT = 8,
  parameter int CNT_W = 8
) ();
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic             rd_valid;
  logic             rd_ready;
  logic [IDX_W-1:0] rd_index;
  logic [CNT_W-1:0] rd_data;

  modport master (
    output rd_valid,
    output rd_index,
    output rd_data,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_index,
    input  rd_data,
    output rd_ready
  );
endinterface
`default_nettype wire

// File: rtl/snn_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module   : snn_rate_decoder
// Purpose  : Rate decoder for the output spike trains. Counts spikes per
//            neuron over WINDOW enabled cycles (saturating), then streams the
//            counts out as (index, count) words over a valid/ready handshake.
// Option   : SNN_READOUT_ARGMAX_EN - adds a running argmax over the drained
//            counts (strict '>' so ties go to the lowest index).
// Revision : 1.0 - initial release
// ============================================================================
module snn_rate_decoder #(
  parameter int N_OUT  = 8,
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16,
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [N_OUT-1:0]     spikes_in,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_W-1:0]     winner,
  output logic                 winner_valid,
  snn_rate_decoder_if.master   rd
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [15:0]      WLAST   = 16'(WINDOW - 1);
  localparam logic [IDX_W-1:0] KLAST   = IDX_W'(N_OUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q;
  logic [15:0]      wcnt_q;
  logic [IDX_W-1:0] k_q;
  logic [IDX_W-1:0] k_d;
  logic [CNT_W-1:0] cnt_q [N_OUT];
  logic [CNT_W-1:0] cnt_d [N_OUT];
  logic             busy_q;
  logic             rd_valid_q;
  logic [CNT_W-1:0] rd_data_q;
  logic             done_q;

  // Saturating per-neuron increment for the current spike vector.
  always_comb begin
    for (int i = 0; i < N_OUT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (spikes_in[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Read pointer for the word following the current one.
  always_comb begin
    k_d = k_q + IDX_W'(1);
  end

`ifdef SNN_READOUT_ARGMAX_EN
  logic [CNT_W-1:0] max_q;
  logic [CNT_W-1:0] max_d;
  logic [IDX_W-1:0] arg_q;
  logic [IDX_W-1:0] arg_d;
  logic [IDX_W-1:0] winner_q;
  logic             winner_valid_q;

  // Running max including the word being transferred; strict compare keeps the lowest index on ties.
  always_comb begin
    max_d = max_q;
    arg_d = arg_q;
    if (rd_data_q > max_q) begin
      max_d = rd_data_q;
      arg_d = k_q;
    end
  end

  assign winner       = winner_q;
  assign winner_valid = winner_valid_q;
`else
  assign winner       = '0;
  assign winner_valid = 1'b0;
`endif

  // Window FSM: IDLE -> ACCUM (integrate) -> DRAIN (stream counts) -> IDLE; frozen when ena=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      k_q        <= '0;
      for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
`ifdef SNN_READOUT_ARGMAX_EN
      max_q          <= '0;
      arg_q          <= '0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
`endif
    end else if (ena) begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
            wcnt_q  <= '0;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ACCUM;
`ifdef SNN_READOUT_ARGMAX_EN
            max_q          <= '0;
            arg_q          <= '0;
            winner_valid_q <= 1'b0;
`endif
          end
        end
        S_ACCUM: begin
          cnt_q  <= cnt_d;
          wcnt_q <= wcnt_q + 16'd1;
          if (wcnt_q == WLAST) begin
            // First word must already include this last sample.
            state_q    <= S_DRAIN;
            k_q        <= '0;
            rd_valid_q <= 1'b1;
            rd_data_q  <= cnt_d[0];
          end
        end
        S_DRAIN: begin
          if (rd.rd_ready) begin
`ifdef SNN_READOUT_ARGMAX_EN
            max_q <= max_d;
            arg_q <= arg_d;
`endif
            if (k_q == KLAST) begin
              state_q    <= S_IDLE;
              k_q        <= '0;
              rd_valid_q <= 1'b0;
              rd_data_q  <= '0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
`ifdef SNN_READOUT_ARGMAX_EN
              winner_q       <= arg_d;
              winner_valid_q <= 1'b1;
`endif
            end else begin
              k_q       <= k_d;
              rd_data_q <= cnt_q[k_d];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_index = k_q;
  assign rd.rd_data  = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_snn_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_snn_rate_decoder
// Purpose  : Scoreboard bench for snn_rate_decoder. Instance A uses WINDOW=16,
//            instance B uses WINDOW=300 for the saturation case. Expected
//            count words are modelled from the driven spikes and queued.
// Option   : honours SNN_READOUT_ARGMAX_EN for the winner checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snn_rate_decoder;

  localparam int N  = 8;
  localparam int WA = 16;
  localparam int WB = 300;

  typedef struct {
    int idx;
    int data;
  } item_t;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] spikes_in;
  logic       start;
  logic       busy;
  logic       done;
  logic [2:0] winner;
  logic       winner_valid;

  logic       b_ena;
  logic [7:0] b_spikes;
  logic       b_start;
  logic       b_busy;
  logic       b_done;
  logic [2:0] b_winner;
  logic       b_wv;

  int n_chk  = 0;
  int n_pass = 0;
  item_t exp_q[$];
  int    exp_win;

  snn_rate_decoder_if #(.N_OUT(N), .CNT_W(8)) ra ();
  snn_rate_decoder_if #(.N_OUT(N), .CNT_W(8)) rb ();

  snn_rate_decoder #(.N_OUT(N), .CNT_W(8), .WINDOW(WA)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .spikes_in    (spikes_in),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .winner       (winner),
    .winner_valid (winner_valid),
    .rd           (ra)
  );

  snn_rate_decoder #(.N_OUT(N), .CNT_W(8), .WINDOW(WB)) u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (b_ena),
    .spikes_in    (b_spikes),
    .start        (b_start),
    .busy         (b_busy),
    .done         (b_done),
    .winner       (b_winner),
    .winner_valid (b_wv),
    .rd           (rb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero();
    chk("z_busy",   busy, 0);
    chk("z_rdv",    ra.rd_valid, 0);
    chk("z_rdidx",  ra.rd_index, 0);
    chk("z_rddata", ra.rd_data, 0);
    chk("z_done",   done, 0);
    chk("z_winner", winner, 0);
    chk("z_wv",     winner_valid, 0);
  endtask

  // Start a window on A, drive spikes, model the counts, queue expected words.
  task automatic run_window(input logic [7:0] pat, input bit rnd, input int gap_at,
                            input int gap_len, input bit poke, input int exp_lat);
    int m[N];
    int sampled = 0;
    int cyc = 0;
    int best = 0;
    logic [7:0] cur;
    for (int i = 0; i < N; i++) m[i] = 0;
    ena = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start", busy, 1);
    chk("wv_clear", winner_valid, 0);
    while (!ra.rd_valid && cyc < 100) begin
      cyc++;
      ena = !(gap_len > 0 && cyc > gap_at && cyc <= gap_at + gap_len);
      cur = rnd ? 8'($urandom) : pat;
      spikes_in = cur;
      start = poke && (cyc == 3);
      if (ena && sampled < WA) begin
        sampled++;
        for (int i = 0; i < N; i++) if (cur[i] && m[i] < 255) m[i]++;
      end
      step();
    end
    start = 1'b0;
    ena = 1'b1;
    spikes_in = 8'hFF;
    chk("rdv_latency", cyc, exp_lat);
    chk("busy_accum", busy, 1);
    exp_win = 0;
    for (int i = 0; i < N; i++) begin
      exp_q.push_back('{idx: i, data: m[i]});
      if (m[i] > best) begin
        best = m[i];
        exp_win = i;
      end
    end
  endtask

  // Drain A: optional stall at one index, optional start pokes during drain.
  task automatic drain(input int stall_idx, input int stall_len, input bit poke);
    int guard = 0;
    int stalled = 0;
    int dones = 0;
    item_t it;
    while (exp_q.size() > 0 && guard < 100) begin
      guard++;
      if (stall_idx >= 0 && stalled < stall_len && exp_q[0].idx == stall_idx) begin
        ra.rd_ready = 1'b0;
        step();
        stalled++;
        chk("stall_valid", ra.rd_valid, 1);
        chk("stall_index", ra.rd_index, stall_idx);
        chk("stall_data",  ra.rd_data, exp_q[0].data);
        if (done) dones++;
      end else begin
        ra.rd_ready = 1'b1;
        it = exp_q.pop_front();
        chk("rd_valid", ra.rd_valid, 1);
        chk("rd_index", ra.rd_index, it.idx);
        chk("rd_data",  ra.rd_data, it.data);
        start = poke && (it.idx == 3 || it.idx == N - 1);
        step();
        start = 1'b0;
        if (done) dones++;
      end
    end
    ra.rd_ready = 1'b0;
    chk("drain_in_time", (guard < 100) ? 1 : 0, 1);
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    chk("rdv_end", ra.rd_valid, 0);
`ifdef SNN_READOUT_ARGMAX_EN
    chk("winner", winner, exp_win);
    chk("winner_valid", winner_valid, 1);
`else
    chk("winner_off", winner, 0);
    chk("wv_off", winner_valid, 0);
`endif
    step();
    if (done) dones++;
    chk("done_count", dones, 1);
    chk("busy_idle", busy, 0);
`ifdef SNN_READOUT_ARGMAX_EN
    chk("wv_hold", winner_valid, 1);
`endif
  endtask

  initial begin
    item_t it;
    int cyc;
    rst_n = 1'b0;
    ena = 1'b1;
    start = 1'b0;
    spikes_in = 8'h00;
    ra.rd_ready = 1'b0;
    b_ena = 1'b1;
    b_start = 1'b0;
    b_spikes = 8'h00;
    rb.rd_ready = 1'b0;
    repeat (3) step();
    check_zero();
    rst_n = 1'b1;
    step();

    // Constant pattern, tie between neurons 0 and 2.
    run_window(8'b0000_0101, 1'b0, 0, 0, 1'b0, 16);
    drain(-1, 0, 1'b0);

    // Reset in the middle of a drain at k=3.
    run_window(8'hA5, 1'b0, 0, 0, 1'b0, 16);
    ra.rd_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      it = exp_q.pop_front();
      chk("pre_rst_data", ra.rd_data, it.data);
      step();
    end
    ra.rd_ready = 1'b0;
    chk("pre_rst_k3", ra.rd_index, 3);
    #2 rst_n = 1'b0;
    #1 check_zero();
    step();
    chk("rst_no_done", done, 0);
    rst_n = 1'b1;
    exp_q.delete();
    step();
    run_window(8'h01, 1'b0, 0, 0, 1'b0, 16);
    drain(-1, 0, 1'b0);

    // Random spikes with backpressure at index 2.
    run_window(8'h00, 1'b1, 0, 0, 1'b0, 16);
    drain(2, 5, 1'b0);

    // Clock enable low for 4 cycles inside the window.
    run_window(8'hFF, 1'b0, 4, 4, 1'b0, 20);
    drain(-1, 0, 1'b0);

    // Start pulsed during ACCUM and DRAIN (including the final transfer).
    run_window(8'h96, 1'b0, 0, 0, 1'b1, 16);
    drain(-1, 0, 1'b1);

    // Saturation on the long-window instance.
    b_spikes = 8'h08;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    cyc = 0;
    while (!rb.rd_valid && cyc < 400) begin
      cyc++;
      step();
    end
    chk("b_latency", cyc, WB);
    rb.rd_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk("b_index", rb.rd_index, i);
      chk("b_data", rb.rd_data, (i == 3) ? 255 : 0);
      step();
    end
    rb.rd_ready = 1'b0;
    chk("b_done", b_done, 1);
    chk("b_busy", b_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snn_rate_decoder.md
# snn_rate_decoder

Output-side readout for the spiking neural net: integrates the spike trains emitted by the output neurons over a fixed window into per-neuron spike counts (rate decoding), then streams the counts out through a valid/ready handshake. It is the decoder for the network's spike encoding and sits between the neuron array's output spikes and the host/test logic that interprets classification results.

## Interface
- `N_OUT`, 8: number of output neurons / spike lines.
- `CNT_W`, 8: width of each spike counter, saturating.
- `WINDOW`, 16: number of sampled cycles per integration window; legal range 1..65535.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ena` input 1: clock enable. When low, all state is frozen.
- `spikes_in` input N_OUT: one spike bit per output neuron, sampled every enabled ACCUM cycle.
- `start` input 1: begin a new window. Accepted only in IDLE with ena=1.
- `busy` output 1: high in ACCUM and DRAIN.
- `rd_valid` output 1: count word available.
- `rd_ready` input 1: consumer accepts the word.
- `rd_index` output max(1,$clog2(N_OUT)): neuron index of the current word.
- `rd_data` output CNT_W: spike count of neuron `rd_index`.
- `done` output 1: one-cycle pulse after the last word transfers.
- `winner` output max(1,$clog2(N_OUT)): argmax neuron (see Configuration).
- `winner_valid` output 1: winner is meaningful.

## Operation
- State machine IDLE → ACCUM → DRAIN → IDLE, registered. No transitions occur while ena=0.
- IDLE:
  - On start=1: clear all counters and the 16-bit window counter `wcnt`, then enter ACCUM.
  - Accepting start also clears winner_valid.
- ACCUM:
  - Each enabled cycle, for every i with spikes_in[i]=1, cnt[i] increments and saturates at 2^CNT_W−1.
  - `wcnt` increments each enabled cycle.
  - The cycle where wcnt==WINDOW−1 is the last sample; the next state is DRAIN with the read pointer k=0.
- DRAIN:
  - rd_valid=1, rd_index=k, rd_data=cnt[k], all driven from registers.
  - A transfer occurs on rd_valid & rd_ready & ena, and advances k.
  - When the transfer with k=N_OUT−1 occurs: next state is IDLE and done pulses high for one cycle.
  - spikes_in is ignored in DRAIN.
- start is ignored while busy. A start coinciding with the final DRAIN transfer is also ignored, because the state is still DRAIN on that edge.
- While rd_ready=0, rd_valid, rd_index and rd_data hold stable.

## Timing
- Reset values, applied asynchronously:
  - State IDLE; counters, wcnt and k cleared.
  - busy=0, rd_valid=0, rd_index=0, rd_data=0, done=0, winner=0, winner_valid=0.
- Reset asserted mid-window or mid-drain aborts the operation. No done pulse is produced.
- With start accepted at edge E and ena held high:
  - spikes are sampled at edges E+1 … E+WINDOW;
  - rd_valid rises after edge E+WINDOW;
  - busy is high from after E until after the final transfer edge.
- Minimum drain is N_OUT cycles with rd_ready held high.
- done and winner_valid rise after the final transfer edge. winner_valid then holds until the next accepted start or reset.
- Cycles with ena=0 extend the window and the drain without changing any state.

## Configuration
- `SNN_READOUT_ARGMAX_EN` defined:
  - a running max/argmax is updated on each DRAIN transfer, with a strict greater-than compare so ties resolve to the lowest index;
  - winner holds the result and winner_valid asserts together with done.
- Not defined: winner and winner_valid are tied to 0 and no compare logic is built.

## Test plan
- Reset mid-DRAIN (k=3), then release: all outputs are 0 after reset; a following start with spikes_in=8'h01 and WINDOW=16 yields rd_data=16 at index 0 and 0 elsewhere.
- spikes_in=8'b0000_0101 held constant, WINDOW=16, rd_ready=1: rd_valid rises 16 cycles after start; the words are 16,0,16,0,0,0,0,0; done pulses once; with ARGMAX_EN, winner=0 (tie resolved to the lowest index) and winner_valid=1.
- Saturation: WINDOW=300, spikes_in=8'h08: cnt[3]=255, all other counts 0.
- Backpressure: rd_ready=0 for 5 cycles at index 2: rd_valid stays 1, rd_index=2 and rd_data are unchanged, no advance; after rd_ready returns to 1, the drain completes and done pulses exactly once.
- ena low for 4 cycles inside ACCUM with spikes_in=8'hFF, WINDOW=16: every count is 16, and rd_valid rises 20 cycles after start.
- start pulsed during ACCUM and during DRAIN: it is ignored, the counts are unaffected, and exactly one done pulse is produced per accepted start.
